// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, error pulses, optional FWFT.
// Latency: flags 1 cycle after the accepting edge; data_out 1 cycle after a read (FWFT=0) or after the write into empty (FWFT=1).
// Backpressure: writes when full and reads when empty are dropped and flagged with a one-cycle overflow/underflow pulse.
module fifo_sync_flags #(
    parameter int Depth    = 8,
    parameter int Width    = 8,
    parameter int AF_Level = Depth - 2,
    parameter int AE_Level = 2,
    parameter int FWFT     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     w_en,
    input  logic                     r_en,
    input  logic [Width-1:0]         data_in,
    output logic [Width-1:0]         data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(Depth):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PW = $clog2(Depth);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(Depth);
    localparam logic [CW-1:0] AF_C    = CW'(AF_Level);
    localparam logic [CW-1:0] AE_C    = CW'(AE_Level);

    // Reject illegal configurations at elaboration rather than building a broken FIFO.
    generate
        if (Depth < 4 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
            $error("fifo_sync_flags: Depth must be a power of two and at least 4");
        end
        if (AF_Level < 1 || AF_Level > Depth) begin : g_bad_af
            $error("fifo_sync_flags: AF_Level must be in 1..Depth");
        end
        if (AE_Level < 0 || AE_Level >= AF_Level) begin : g_bad_ae
            $error("fifo_sync_flags: AE_Level must be in 0..AF_Level-1");
        end
    endgenerate

    logic [Width-1:0] mem [Depth];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_acc;
    logic             rd_acc;

    // Acceptance uses the registered flags, so a read frees no space for a write on the same edge.
    assign wr_acc = w_en & ~full;
    assign rd_acc = r_en & ~empty;

    // Flags come straight from the count register: glitch-free, no path from w_en/r_en.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // Storage array; deliberately not reset, contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers, occupancy and error pulses; reset wins over any request on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            overflow  <= w_en & full;
            underflow <= r_en & empty;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented continuously; forced to zero while nothing is queued.
            always_comb begin
                data_out = '0;
                if (!empty) begin
                    data_out = mem[rd_ptr];
                end
            end
        end else begin : g_std
            logic [Width-1:0] data_q;

            // Registered read port: loads only on an accepted read, holds across rejected ones.
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q <= '0;
                end else if (rd_acc) begin
                    data_q <= mem[rd_ptr];
                end
            end

            assign data_out = data_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench for fifo_sync_flags: standard-read instance plus an FWFT instance.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
// Expected values are hand-derived constants per test step.
module tb_fifo_sync_flags;

    logic       clk = 1'b0;
    logic       rst;
    logic       w_en, r_en;
    logic [7:0] data_in, data_out;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;

    logic       f_w_en, f_r_en;
    logic [7:0] f_data_in, f_data_out;
    logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [3:0] f_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fifo_sync_flags #(.Depth(8), .Width(8), .AF_Level(6), .AE_Level(2), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .data_in(data_in),
        .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
    );

    fifo_sync_flags #(.Depth(8), .Width(8), .AF_Level(6), .AE_Level(2), .FWFT(1)) dut_f (
        .clk(clk), .rst(rst), .w_en(f_w_en), .r_en(f_r_en), .data_in(f_data_in),
        .data_out(f_data_out), .full(f_full), .empty(f_empty), .almost_full(f_almost_full),
        .almost_empty(f_almost_empty), .count(f_count), .overflow(f_overflow), .underflow(f_underflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; w_en = 1'b0; r_en = 1'b0;
        f_w_en = 1'b0; f_r_en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic write_word(input logic [7:0] d);
        w_en = 1'b1; data_in = d;
        tick();
        w_en = 1'b0;
    endtask

    logic [7:0] drain_exp [7];

    initial begin
        rst = 1'b1; w_en = 1'b0; r_en = 1'b0; data_in = '0;
        f_w_en = 1'b0; f_r_en = 1'b0; f_data_in = '0;

        // Reset state
        do_reset();
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_ae", 32'(almost_empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_af", 32'(almost_full), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_udf", 32'(underflow), 0);
        check("rst_dout", 32'(data_out), 0);

        // Basic: write 15..19, read back in order
        for (int i = 0; i < 5; i++) begin
            write_word(8'(15 + i));
            check("basic_wr_count", 32'(count), 32'(i + 1));
            check("basic_wr_empty", 32'(empty), 0);
        end
        check("basic_ae_at5", 32'(almost_empty), 0);
        check("basic_af_at5", 32'(almost_full), 0);
        for (int i = 0; i < 5; i++) begin
            r_en = 1'b1;
            tick();
            check("basic_rd_data", 32'(data_out), 32'(15 + i));
            check("basic_rd_count", 32'(count), 32'(4 - i));
            check("basic_no_err", 32'({overflow, underflow}), 0);
        end
        r_en = 1'b0;
        check("basic_end_empty", 32'(empty), 1);

        // Full / overflow
        do_reset();
        for (int i = 0; i < 8; i++) begin
            write_word(8'(60 + i));
            check("full_af", 32'(almost_full), (i + 1 >= 6) ? 1 : 0);
            check("full_full", 32'(full), (i + 1 == 8) ? 1 : 0);
        end
        for (int i = 0; i < 4; i++) begin
            w_en = 1'b1; data_in = 8'(70 + i);
            tick();
            check("ovf_pulse", 32'(overflow), 1);
            check("ovf_count", 32'(count), 8);
        end
        w_en = 1'b0;
        tick();
        check("ovf_clear", 32'(overflow), 0);
        for (int i = 0; i < 8; i++) begin
            r_en = 1'b1;
            tick();
            check("full_drain", 32'(data_out), 32'(60 + i));
        end
        r_en = 1'b0;
        check("full_drain_empty", 32'(empty), 1);

        // Empty / underflow: data_out must stay at its reset value
        do_reset();
        for (int i = 0; i < 8; i++) begin
            r_en = 1'b1;
            tick();
            check("udf_pulse", 32'(underflow), 1);
            check("udf_count", 32'(count), 0);
            check("udf_dout", 32'(data_out), 0);
        end
        r_en = 1'b0;
        tick();
        check("udf_clear", 32'(underflow), 0);

        // Wrap-around and simultaneous read/write
        do_reset();
        for (int i = 0; i < 8; i++) write_word(8'(80 + i));
        for (int i = 0; i < 4; i++) begin
            r_en = 1'b1;
            tick();
            check("wrap_rd", 32'(data_out), 32'(80 + i));
        end
        r_en = 1'b0;
        check("wrap_count4", 32'(count), 4);
        for (int i = 0; i < 4; i++) write_word(8'(88 + i));
        check("wrap_full", 32'(full), 1);
        // First both-cycle hits a full FIFO: 92 rejected, 84 read out, count 7.
        // Remaining three both-cycles run at count 7: 93..95 in, 85..87 out.
        for (int i = 0; i < 4; i++) begin
            w_en = 1'b1; r_en = 1'b1; data_in = 8'(92 + i);
            tick();
            check("both_dout", 32'(data_out), 32'(84 + i));
            check("both_count", 32'(count), 7);
            check("both_ovf", 32'(overflow), (i == 0) ? 1 : 0);
        end
        w_en = 1'b0; r_en = 1'b0;
        drain_exp = '{8'd88, 8'd89, 8'd90, 8'd91, 8'd93, 8'd94, 8'd95};
        for (int i = 0; i < 7; i++) begin
            r_en = 1'b1;
            tick();
            check("wrap_drain", 32'(data_out), 32'(drain_exp[i]));
        end
        r_en = 1'b0;
        check("wrap_end_empty", 32'(empty), 1);

        // FWFT instance
        check("fwft_rst_dout", 32'(f_data_out), 0);
        check("fwft_rst_empty", 32'(f_empty), 1);
        f_w_en = 1'b1; f_data_in = 8'hA5;
        tick();
        f_w_en = 1'b0;
        check("fwft_show", 32'(f_data_out), 32'h A5);
        check("fwft_count1", 32'(f_count), 1);
        tick();
        check("fwft_hold", 32'(f_data_out), 32'h A5);
        f_r_en = 1'b1;
        tick();
        f_r_en = 1'b0;
        check("fwft_pop_empty", 32'(f_empty), 1);
        check("fwft_pop_dout", 32'(f_data_out), 0);
        f_w_en = 1'b1; f_data_in = 8'h11;
        tick();
        f_data_in = 8'h22;
        tick();
        f_w_en = 1'b0;
        check("fwft_head", 32'(f_data_out), 32'h11);
        f_r_en = 1'b1;
        tick();
        f_r_en = 1'b0;
        check("fwft_next", 32'(f_data_out), 32'h22);

        // Reset mid-stream: reset beats a concurrent write
        do_reset();
        for (int i = 0; i < 5; i++) write_word(8'(i + 1));
        check("mid_count5", 32'(count), 5);
        rst = 1'b1; w_en = 1'b1; data_in = 8'h99;
        tick();
        rst = 1'b0; w_en = 1'b0;
        check("mid_count0", 32'(count), 0);
        check("mid_empty", 32'(empty), 1);
        check("mid_dout", 32'(data_out), 0);
        write_word(8'h42);
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
        check("mid_first_after", 32'(data_out), 32'h42);
        check("mid_end_empty", 32'(empty), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
